mod_pow: RTL and testbench

Iterative modular exponentiator: computes out = inx^inn mod inm by right-to-left square-and-multiply. Every product is reduced on the fly by a bit-serial interleaved modular multiplier, so no 2X-bit product is ever formed. This successor to the plain wrap-around power unit adds a run-time modulus, a parametrised multiplier latency, an error flag, and a deterministic cycle count. It sits behind a start/ready handshake as a slave of the datapath controller.

---
 rtl/mod_pow_pkg.sv | 19 +
 rtl/mod_pow_if.sv | 19 +
 rtl/mod_pow_mul.sv | 57 +++++
 rtl/mod_pow.sv | 118 +++++++++++
 tb/tb_mod_pow.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/mod_pow_pkg.sv
// Shared types and helpers for the mod_pow modular exponentiator.
package mod_pow_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RED  = 2'd1,
    MUL  = 2'd2,
    SQR  = 2'd3
  } state_t;

  localparam int CYCLES_W = 32;

  // Multiplicative identity modulo m: 1, except 0 when everything collapses (m==1).
  function automatic logic [63:0] one_mod(input logic [63:0] m, input int x);
    if (x < 1 || m == 64'd1) return 64'd0;
    return 64'd1;
  endfunction

endpackage

// File: rtl/mod_pow_if.sv
// Request/result bundle between the datapath controller (master) and mod_pow (slave).
interface mod_pow_if #(
  parameter int X = 16,
  parameter int N = 8
);
  // Handshake: a request is accepted on the rising edge where start=1 and ready=1;
  // operands are latched on that edge, and out/err are valid whenever ready=1.
  logic         start;
  logic [X-1:0] inx;
  logic [N-1:0] inn;
  logic [X-1:0] inm;
  logic         ready;
  logic [X-1:0] out;
  logic         err;
  logic [1:0]   state;

  modport slave  (input start, inx, inn, inm, output ready, out, err, state);
  modport master (output start, inx, inn, inm, input ready, out, err, state);
endinterface

// File: rtl/mod_pow_mul.sv
// Bit-serial interleaved modular multiplier: r = A*B mod M in 1 launch + X iteration cycles.
module mod_mul #(
  parameter int X = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic [X-1:0] A,
  input  logic [X-1:0] B,
  input  logic [X-1:0] M,
  output logic         busy,
  output logic         done,
  output logic [X-1:0] r
);
  localparam int W  = X + 2;
  localparam int CW = (X > 1) ? $clog2(X) : 1;

  logic [X-1:0]  a_sh, b_q, m_q, r_q, r_nxt;
  logic [CW-1:0] cnt;
  logic          busy_q;
  logic [W-1:0]  m_ext, t0, t1;

  // r < m keeps 2r + B below 3m, so two conditional subtractions suffice.
  always_comb begin
    m_ext = {2'b00, m_q};
    t0    = {1'b0, r_q, 1'b0} + (a_sh[X-1] ? {2'b00, b_q} : '0);
    t1    = (t0 >= m_ext) ? t0 - m_ext : t0;
    r_nxt = (t1 >= m_ext) ? X'(t1 - m_ext) : X'(t1);
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt == CW'(X - 1));
  assign r    = done ? r_nxt : r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt    <= '0;
      a_sh   <= '0;
      b_q    <= '0;
      m_q    <= '0;
      r_q    <= '0;
    end else if (go) begin
      busy_q <= 1'b1;
      cnt    <= '0;
      a_sh   <= A;
      b_q    <= B;
      m_q    <= M;
      r_q    <= '0;
    end else if (busy_q) begin
      r_q  <= r_nxt;
      a_sh <= a_sh << 1;
      cnt  <= cnt + CW'(1);
      if (done) busy_q <= 1'b0;
    end
  end
endmodule

// File: rtl/mod_pow.sv
// Right-to-left square-and-multiply modular exponentiator: out = inx^inn mod inm.
// Optional busy-cycle counter port enabled by MOD_POW_CYCLES_EN.
module mod_pow
  import mod_pow_pkg::*;
#(
  parameter int X = 16,
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                rst,
  mod_pow_if.slave            bus
`ifdef MOD_POW_CYCLES_EN
  ,
  output logic [CYCLES_W-1:0] cycles
`endif
);
  state_t       state_q, state_d;
  logic [X-1:0] x_q, a_q, b_q, m_q, out_q, a_fin;
  logic [N-1:0] n_q;
  logic         err_q;
  logic         accept, phase_end, shift_n, finish;
  logic         mm_go, mm_busy, mm_done;
  logic [X-1:0] mm_a, mm_b, mm_r;

  assign accept    = bus.start && (state_q == IDLE);
  assign phase_end = (state_q != IDLE) && mm_done;
  assign mm_go     = (state_q != IDLE) && !mm_busy;
  assign a_fin     = (state_q == MUL) ? mm_r : a_q;

  assign bus.ready = (state_q == IDLE);
  assign bus.out   = out_q;
  assign bus.err   = err_q;
  assign bus.state = state_q;

  mod_mul #(.X(X)) u_mul (
    .clk  (clk),
    .rst  (rst),
    .go   (mm_go),
    .A    (mm_a),
    .B    (mm_b),
    .M    (m_q),
    .busy (mm_busy),
    .done (mm_done),
    .r    (mm_r)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A squaring not preceded by MUL consumes a zero exponent bit, so it shifts n too.
  always_comb begin
    state_d = state_q;
    shift_n = 1'b0;
    finish  = 1'b0;
    mm_a    = x_q;
    mm_b    = a_q;
    case (state_q)
      IDLE: if (accept && bus.inm != '0) state_d = RED;
      RED:  begin mm_a = x_q; mm_b = a_q; end
      MUL:  begin mm_a = a_q; mm_b = b_q; end
      SQR:  begin mm_a = b_q; mm_b = b_q; end
      default: ;
    endcase
    if (phase_end) begin
      if (n_q == '0) begin
        state_d = IDLE;
        finish  = 1'b1;
      end else if (n_q[0] && state_q != MUL) begin
        state_d = MUL;
        shift_n = 1'b1;
      end else begin
        state_d = SQR;
        shift_n = (state_q != MUL);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      m_q   <= '0;
      n_q   <= '0;
      out_q <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      x_q   <= bus.inx;
      n_q   <= bus.inn;
      m_q   <= bus.inm;
      err_q <= (bus.inm == '0);
      a_q   <= X'(one_mod(64'(bus.inm), X));
      b_q   <= '0;
      if (bus.inm == '0) out_q <= '0;
    end else if (phase_end) begin
      case (state_q)
        RED:     b_q <= mm_r;
        MUL:     a_q <= mm_r;
        SQR:     b_q <= mm_r;
        default: ;
      endcase
      if (shift_n) n_q <= n_q >> 1;
      if (finish) out_q <= a_fin;
    end
  end

`ifdef MOD_POW_CYCLES_EN
  logic [CYCLES_W-1:0] cyc_q;
  always_ff @(posedge clk) begin
    if (rst)                   cyc_q <= '0;
    else if (accept)           cyc_q <= '0;
    else if (state_q != IDLE)  cyc_q <= cyc_q + CYCLES_W'(1);
  end
  assign cycles = cyc_q;
`endif
endmodule

// File: tb/tb_mod_pow.sv
// Self-checking bench for mod_pow (X=8, N=8); checks cycles too when MOD_POW_CYCLES_EN is defined.
module tb_mod_pow;
  import mod_pow_pkg::*;

  localparam int X  = 8;
  localparam int N  = 8;
  localparam int EW = 25;  // {err, out[7:0], len[15:0]}

  logic clk, rst;
  mod_pow_if #(.X(X), .N(N)) io ();
`ifdef MOD_POW_CYCLES_EN
  logic [CYCLES_W-1:0] cycles;
`endif

  mod_pow #(.X(X), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (io.slave)
`ifdef MOD_POW_CYCLES_EN
    ,
    .cycles (cycles)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_pow(input logic [7:0] x, input logic [7:0] n, input logic [7:0] m);
    int unsigned r, b;
    if (m == 0) return 8'd0;
    r = 1 % int'(m);
    b = int'(x) % int'(m);
    for (int i = 0; i < int'(n); i++) r = (r * b) % int'(m);
    return r[7:0];
  endfunction

  function automatic int ref_len(input logic [7:0] n, input logic [7:0] m);
    int pc, bl;
    pc = 0;
    bl = 0;
    if (m == 0) return 0;
    if (n == 0) return X + 1;
    for (int i = 0; i < 8; i++) if (n[i]) begin pc++; bl = i + 1; end
    return (X + 1) * (1 + pc + bl - 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int k;
    k = 0;
    while (!io.ready && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    if (!io.ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_ready: ready=0 after %0d cycles, required 1", k);
    end
  endtask

  task automatic run(input logic [7:0] x, input logic [7:0] n, input logic [7:0] m);
    wait_ready();
    io.inx   = x;
    io.inn   = n;
    io.inm   = m;
    io.start = 1'b1;
    exp_q.push_back({(m == 8'd0), ref_pow(x, n, m), 16'(ref_len(n, m))});
    @(posedge clk); #1;
    io.start = 1'b0;
    io.inx   = 8'($urandom);
    io.inn   = 8'($urandom);
    io.inm   = 8'($urandom);
  endtask

  // ---------------- scoreboard / compare process ----------------
  bit            pend = 1'b0;
  bit            held_ok;
  int            busy_n;
  logic [7:0]    hold_v;
  logic [EW-1:0] e;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (!io.ready) begin
            busy_n++;
            if (io.out !== hold_v) held_ok = 1'b0;
            if (busy_n > 2000) begin
              check("busy bound", busy_n, 32'(e[15:0]));
              pend = 1'b0;
            end
          end else begin
            check("len", busy_n, 32'(e[15:0]));
            check("out", 32'(io.out), 32'(e[23:16]));
            check("err", 32'(io.err), 32'(e[24]));
            check("hold", 32'(held_ok), 32'd1);
`ifdef MOD_POW_CYCLES_EN
            check("cycles", cycles, 32'(e[15:0]));
`endif
            pend = 1'b0;
          end
        end
        if (!pend && io.start && io.ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected accept", 32'd1, 32'd0);
          end else begin
            e       = exp_q.pop_front();
            pend    = 1'b1;
            busy_n  = 0;
            held_ok = 1'b1;
            hold_v  = io.out;
          end
        end
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int k;
    logic [7:0] rx, rn, rm;
    rst = 1'b1;
    io.start = 1'b0;
    io.inx = '0;
    io.inn = '0;
    io.inm = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset ready", 32'(io.ready), 32'd1);
    check("reset out", 32'(io.out), 32'd0);
    check("reset err", 32'(io.err), 32'd0);

    check("model 3^5%7", 32'(ref_pow(8'd3, 8'd5, 8'd7)), 32'd5);
    check("model len n=5", ref_len(8'd5, 8'd7), 32'd45);
    check("model 200^3%255", 32'(ref_pow(8'd200, 8'd3, 8'd255)), 32'd140);

    run(8'd3, 8'd5, 8'd7);      wait_ready(); check("3^5%7", 32'(io.out), 32'd5);
    run(8'd200, 8'd3, 8'd255);  wait_ready(); check("200^3%255", 32'(io.out), 32'd140);
    run(8'd7, 8'd0, 8'd10);     wait_ready(); check("7^0%10", 32'(io.out), 32'd1);
    run(8'd9, 8'd4, 8'd1);      wait_ready(); check("9^4%1", 32'(io.out), 32'd0);
    run(8'd123, 8'd77, 8'd0);
    check("m=0 ready", 32'(io.ready), 32'd1);
    check("m=0 err", 32'(io.err), 32'd1);
    check("m=0 out", 32'(io.out), 32'd0);
    run(8'd3, 8'd5, 8'd7);      wait_ready();
    check("err cleared", 32'(io.err), 32'd0);
    check("after err out", 32'(io.out), 32'd5);
    run(8'd2, 8'd7, 8'd100);    wait_ready(); check("2^7%100", 32'(io.out), 32'd28);

    // start and operand changes while busy must not disturb the latched operation
    run(8'd3, 8'd5, 8'd7);
    repeat (5) begin @(posedge clk); #1; end
    io.start = 1'b1; io.inx = 8'd50; io.inn = 8'd2; io.inm = 8'd99;
    repeat (3) begin @(posedge clk); #1; end
    io.start = 1'b0;
    wait_ready(); check("busy start ignored", 32'(io.out), 32'd5);

    // reset in the middle of a squaring phase
    run(8'd3, 8'd5, 8'd7);
    k = 0;
    while (io.state != SQR && k < 500) begin @(posedge clk); #1; k++; end
    check("reached SQR", 32'(io.state), 32'(SQR));
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid rst ready", 32'(io.ready), 32'd1);
    check("mid rst out", 32'(io.out), 32'd0);
    check("mid rst err", 32'(io.err), 32'd0);
    run(8'd3, 8'd5, 8'd7);      wait_ready(); check("post rst 3^5%7", 32'(io.out), 32'd5);

    // random sweep, back-to-back requests
    for (int i = 0; i < 250; i++) begin
      rx = 8'($urandom_range(0, 255));
      rn = 8'($urandom_range(0, 255));
      k  = int'($urandom_range(0, 15));
      if (k == 0)      rm = 8'd0;
      else if (k == 1) rm = 8'd1;
      else             rm = 8'($urandom_range(2, 255));
      run(rx, rn, rm);
    end
    wait_ready();
    repeat (3) @(negedge clk);
    check("queue drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
